// File: rtl/fnd_apb_pkg.sv
// Shared types and constants for the FND APB scheduler.
//   state_t     : scheduler FSM states
//   ADDR_*      : FND slave register addresses
//   write_addr  : APB address of the n-th write in an update (FDR, FPR, FCR)
//   write_word  : zero-extended APB write data of the n-th write in an update
package fnd_apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DWELL} state_t;

    localparam logic [3:0] ADDR_FCR = 4'h0;
    localparam logic [3:0] ADDR_FDR = 4'h4;
    localparam logic [3:0] ADDR_FPR = 4'h8;

    localparam int DATA_W = 14;
    localparam int DP_W   = 4;

    function automatic logic [3:0] write_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    write_addr = ADDR_FDR;
            2'd1:    write_addr = ADDR_FPR;
            default: write_addr = ADDR_FCR;
        endcase
    endfunction

    function automatic logic [31:0] write_word(input logic [1:0]        idx,
                                               input logic [DATA_W-1:0] data,
                                               input logic [DP_W-1:0]   dp,
                                               input logic              en);
        case (idx)
            2'd0:    write_word = {{(32-DATA_W){1'b0}}, data};
            2'd1:    write_word = {{(32-DP_W){1'b0}}, dp};
            default: write_word = {31'd0, en};
        endcase
    endfunction

endpackage

// File: rtl/fnd_apb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index searched first; the search wraps from N-1 back to 0
//   grant : one-hot winner (all zero when no request is set)
//   valid : at least one request is set
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    always_comb begin
        // NOTE: every variable gets a default before the loop, otherwise paths
        // that never hit a set request would infer latches.
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fnd_apb_scheduler.sv
// APB master sharing the FND display among NUM_REQ requesters.
// A round-robin winner is latched and pushed to the slave as three writes
// (FDR, FPR, FCR); a dwell period then keeps it on the display.
//   PCLK, PRESETn         : clock, asynchronous active-low reset
//   req/req_data/req_dp/req_en : per-requester level request and packed payload
//   gnt                   : one-hot requester being serviced
//   ack                   : one-cycle pulse when that requester's update completed
//   err                   : one-cycle pulse when a write timed out waiting for PREADY
//   busy                  : FSM is not IDLE
//   PADDR..PENABLE        : APB master outputs; PREADY/PRDATA from the slave
module fnd_apb_scheduler
    import fnd_apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWELL   = 100000,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*14-1:0] req_data,
    input  logic [NUM_REQ*4-1:0]  req_dp,
    input  logic [NUM_REQ-1:0]    req_en,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  err,
    output logic                  busy,
    output logic [3:0]            PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DWELL + 1);

    // The state literal shares its name with the DWELL parameter.
    localparam state_t ST_DWELL = fnd_apb_pkg::DWELL;

    state_t            state;
    logic [1:0]        wcnt;
    logic              gap;
    logic [PW-1:0]     rr_ptr;
    logic [TW-1:0]     tcnt;
    logic [DW-1:0]     dcnt;
    logic [DATA_W-1:0] lat_data;
    logic [DP_W-1:0]   lat_dp;
    logic              lat_en;

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_valid;
    logic [PW-1:0]      sel_idx;
    logic [PW-1:0]      next_ptr;
    logic [DATA_W-1:0]  sel_data;
    logic [DP_W-1:0]    sel_dp;
    logic               sel_en;
    logic [1:0]         wnext;

    // Reads are never issued.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_gnt),
        .valid (arb_valid)
    );

    // Payload of the arbitration winner, picked from the packed inputs.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        sel_dp   = '0;
        sel_en   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_idx  = PW'(i);
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_dp   = req_dp[i*DP_W +: DP_W];
                sel_en   = req_en[i];
            end
        end
    end

    assign next_ptr = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
    assign wnext    = wcnt + 2'd1;
    assign PWRITE   = PSEL;

    // NOTE: all state, including the latched payload, uses non-blocking
    // assignments and is cleared by the asynchronous reset so nothing stale
    // can reach the bus after PRESETn.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wcnt     <= '0;
            gap      <= 1'b0;
            rr_ptr   <= '0;
            tcnt     <= '0;
            dcnt     <= '0;
            lat_data <= '0;
            lat_dp   <= '0;
            lat_en   <= 1'b0;
            gnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        gnt      <= arb_gnt;
                        lat_data <= sel_data;
                        lat_dp   <= sel_dp;
                        lat_en   <= sel_en;
                        rr_ptr   <= next_ptr;
                        wcnt     <= '0;
                        gap      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                        // Outputs are registered, so the first SETUP phase is
                        // already on the bus in the cycle after the grant.
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        PADDR    <= write_addr(2'd0);
                        PWDATA   <= write_word(2'd0, sel_data, sel_dp, sel_en);
                    end
                end
                SETUP: begin
                    // gap marks the idle bus cycle between two writes; the
                    // visible SETUP phase (PSEL=1, PENABLE=0) is one cycle.
                    if (gap) begin
                        gap  <= 1'b0;
                        PSEL <= 1'b1;
                    end else begin
                        PENABLE <= 1'b1;
                        tcnt    <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        tcnt    <= '0;
                        if (wcnt != 2'd2) begin
                            wcnt   <= wnext;
                            gap    <= 1'b1;
                            PADDR  <= write_addr(wnext);
                            PWDATA <= write_word(wnext, lat_data, lat_dp, lat_en);
                            state  <= SETUP;
                        end else begin
                            ack   <= gnt;
                            gnt   <= '0;
                            dcnt  <= '0;
                            state <= ST_DWELL;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // Slave never answered: drop the rest of the update.
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        tcnt    <= '0;
                        err     <= 1'b1;
                        gnt     <= '0;
                        dcnt    <= '0;
                        state   <= ST_DWELL;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_DWELL: begin
                    if (dcnt == DW'(DWELL - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_apb_scheduler.sv
// Scoreboard bench for fnd_apb_scheduler with an FND APB slave model.
module tb_fnd_apb_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DWELL   = 8;
    localparam int TIMEOUT = 16;

    logic                  PCLK = 1'b0;
    logic                  PRESETn;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*14-1:0] req_data;
    logic [NUM_REQ*4-1:0]  req_dp;
    logic [NUM_REQ-1:0]    req_en;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic                  busy;
    logic [3:0]            PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PREADY;
    logic [31:0]           PRDATA;

    fnd_apb_scheduler #(.NUM_REQ(NUM_REQ), .DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_data(req_data),
        .req_dp(req_dp), .req_en(req_en), .gnt(gnt), .ack(ack), .err(err),
        .busy(busy), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [3:0] exp_gnt[$];
    logic [3:0] exp_ack[$];
    int         exp_err;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_ptr;
    logic [13:0] m_data[NUM_REQ];
    logic [3:0]  m_dp[NUM_REQ];
    logic        m_en[NUM_REQ];

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic set_fields(input int i, input logic [13:0] d, input logic [3:0] dp, input logic en);
        m_data[i] = d;
        m_dp[i]   = dp;
        m_en[i]   = en;
        req_data[i*14 +: 14] = d;
        req_dp[i*4 +: 4]     = dp;
        req_en[i]            = en;
    endtask

    task automatic push_grant(input int w);
        exp_gnt.push_back(4'(1 << w));
        m_ptr = (w + 1) % NUM_REQ;
    endtask

    task automatic push_update(input int w);
        push_grant(w);
        exp_wr.push_back('{addr: 4'h4, data: {18'd0, m_data[w]}});
        exp_wr.push_back('{addr: 4'h8, data: {28'd0, m_dp[w]}});
        exp_wr.push_back('{addr: 4'h0, data: {31'd0, m_en[w]}});
        exp_ack.push_back(4'(1 << w));
    endtask

    // ---------------- FND slave: PREADY registered, >=2 ACCESS cycles ----------------
    logic        slave_stall;
    int          acc_cnt;
    int          need;
    logic [31:0] fdr, fpr, fcr;

    initial begin
        PREADY = 1'b0; acc_cnt = 0; need = 2; fdr = '0; fpr = '0; fcr = '0;
        forever begin
            @(posedge PCLK);
            #1;
            if (!PRESETn || PREADY) begin
                PREADY  = 1'b0;
                acc_cnt = 0;
            end else if (PSEL && PENABLE && !slave_stall) begin
                acc_cnt++;
                if (acc_cnt >= need) begin
                    PREADY = 1'b1;
                    case (PADDR)
                        4'h4:    fdr = PWDATA;
                        4'h8:    fpr = PWDATA;
                        4'h0:    fcr = PWDATA;
                        default: ;
                    endcase
                    need = 2 + int'($urandom_range(0, 2));
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          ack_seen = 0;
    int          setup_count = 0;
    int          last_ack_cyc;
    logic        have_last_ack;
    logic [3:0]  prev_gnt;
    int          setup_run, acc_run;
    logic        need_gap, stable_bad, pwrite_bad;
    logic [3:0]  sv_addr;
    logic [31:0] sv_data;

    initial begin
        have_last_ack = 0; prev_gnt = '0; setup_run = 0; acc_run = 0;
        need_gap = 0; stable_bad = 0; pwrite_bad = 0; sv_addr = '0; sv_data = '0;
        forever begin
            @(negedge PCLK);
            cyc++;
            if (!PRESETn) begin
                have_last_ack = 0; prev_gnt = '0; setup_run = 0; acc_run = 0;
                need_gap = 0; stable_bad = 0; pwrite_bad = 0;
            end else begin
                if (gnt != '0 && prev_gnt == '0) begin
                    if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
                    else check("gnt_winner", 32'(gnt), 32'(exp_gnt.pop_front()));
                    if (have_last_ack)
                        check("dwell_before_gnt", 32'((cyc - last_ack_cyc) >= DWELL), 32'd1);
                end
                prev_gnt = gnt;

                if (ack != '0) begin
                    if (exp_ack.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
                    else check("ack", 32'(ack), 32'(exp_ack.pop_front()));
                    last_ack_cyc  = cyc;
                    have_last_ack = 1;
                    ack_seen++;
                end

                if (err) begin
                    if (exp_err == 0) check("err_unexpected", 32'(err), 32'd0);
                    else begin
                        exp_err--;
                        check("err_access_cycles", 32'(acc_run), 32'(TIMEOUT));
                    end
                end

                if (need_gap) begin
                    check("psel_gap", 32'(PSEL), 32'd0);
                    need_gap = 0;
                end
                if (PSEL && PWRITE !== 1'b1) pwrite_bad = 1;

                if (PSEL && !PENABLE) begin
                    if (setup_run == 0) setup_count++;
                    setup_run++;
                    acc_run    = 0;
                    stable_bad = 0;
                    sv_addr    = PADDR;
                    sv_data    = PWDATA;
                end else if (PSEL && PENABLE) begin
                    if (setup_run != 0) begin
                        check("setup_len", 32'(setup_run), 32'd1);
                        setup_run = 0;
                    end
                    acc_run++;
                    if (PADDR !== sv_addr || PWDATA !== sv_data) stable_bad = 1;
                    if (PREADY) begin
                        if (exp_wr.size() == 0) check("write_unexpected", {28'd0, PADDR}, 32'hFFFF_FFFF);
                        else begin
                            wr_t e;
                            e = exp_wr.pop_front();
                            check("write_addr", 32'(PADDR), 32'(e.addr));
                            check("write_data", PWDATA, e.data);
                        end
                        check("access_stable", 32'(stable_bad), 32'd0);
                        check("pwrite_high", 32'(pwrite_bad), 32'd0);
                        pwrite_bad = 0;
                        need_gap   = 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_gnt();
        for (int k = 0; k < 100 && gnt != '0; k++) @(negedge PCLK);
        for (int k = 0; k < 100 && gnt == '0; k++) @(negedge PCLK);
        check("gnt_seen", 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && busy !== 1'b0; k++) @(negedge PCLK);
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int w, base;
        logic busy_hi;
        logic [3:0] mask;

        PRESETn = 1'b0; req = '0; req_data = '0; req_dp = '0; req_en = '0;
        PRDATA = '0; slave_stall = 1'b0; m_ptr = 0; exp_err = 0;
        for (int i = 0; i < NUM_REQ; i++) set_fields(i, '0, '0, 1'b0);

        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        #2 PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        check("idle_no_req_busy", 32'(busy), 32'd0);

        // Single request from requester 1
        set_fields(1, 14'd1234, 4'b0010, 1'b1);
        w = rr_pick(4'b0010, m_ptr);
        push_update(w);
        req = 4'b0010;
        wait_gnt();
        req = '0;
        wait_idle();
        check("t1_slave_fdr", fdr, 32'd1234);
        check("t1_slave_fpr", fpr, 32'd2);
        check("t1_slave_fcr", fcr, 32'd1);

        // Reset in the middle of an ACCESS phase
        slave_stall = 1'b1;
        set_fields(0, 14'd42, 4'h1, 1'b1);
        push_grant(rr_pick(4'b0001, m_ptr));
        req = 4'b0001;
        wait_gnt();
        req = '0;
        for (int k = 0; k < 20 && PENABLE !== 1'b1; k++) @(negedge PCLK);
        check("t5_in_access", 32'(PENABLE), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("t5_psel_async", 32'(PSEL), 32'd0);
        check("t5_penable_async", 32'(PENABLE), 32'd0);
        check("t5_gnt_async", 32'(gnt), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        exp_wr.delete(); exp_gnt.delete(); exp_ack.delete(); exp_err = 0;
        m_ptr = 0;
        slave_stall = 1'b0;
        @(negedge PCLK);
        #2 PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        check("t5_idle_after_release", 32'(busy), 32'd0);

        // All requesters held: rotation from pointer 0
        for (int i = 0; i < NUM_REQ; i++)
            set_fields(i, 14'(100 * (i + 1) + i), 4'(1 << i), 1'(i % 2));
        for (int n = 0; n < 5; n++) push_update(rr_pick(4'hF, m_ptr));
        base = ack_seen;
        req  = 4'hF;
        for (int k = 0; k < 1000 && ack_seen < base + 5; k++) @(negedge PCLK);
        req = '0;
        check("t2_ack_count", 32'(ack_seen - base), 32'd5);
        wait_idle();

        // Data change right after grant; held request re-served with new data
        set_fields(0, 14'd1234, 4'h5, 1'b1);
        push_update(rr_pick(4'b0001, m_ptr));
        req = 4'b0001;
        wait_gnt();
        set_fields(0, 14'd5678, 4'h5, 1'b1);
        push_update(rr_pick(4'b0001, m_ptr));
        wait_gnt();
        req = '0;
        wait_idle();
        check("t4_slave_fdr", fdr, 32'd5678);

        // Slave never ready: timeout
        slave_stall = 1'b1;
        set_fields(2, 14'd777, 4'h3, 1'b1);
        push_grant(rr_pick(4'b0100, m_ptr));
        exp_err++;
        base = setup_count;
        req  = 4'b0100;
        wait_gnt();
        req = '0;
        for (int k = 0; k < 100 && err !== 1'b1; k++) @(negedge PCLK);
        check("t3_err_seen", 32'(err), 32'd1);
        busy_hi = 1'b1;
        repeat (DWELL - 1) begin
            @(negedge PCLK);
            if (busy !== 1'b1) busy_hi = 1'b0;
        end
        check("t3_busy_in_dwell", 32'(busy_hi), 32'd1);
        @(negedge PCLK);
        check("t3_idle_after_dwell", 32'(busy), 32'd0);
        check("t3_only_fdr_tried", 32'(setup_count - base), 32'd1);
        slave_stall = 1'b0;

        // Random traffic
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++)
                set_fields(i, 14'($urandom_range(0, 16383)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)));
            w = rr_pick(mask, m_ptr);
            push_update(w);
            req = mask;
            wait_gnt();
            req = '0;
            for (int i = 0; i < NUM_REQ; i++)
                set_fields(i, 14'($urandom_range(0, 16383)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)));
            wait_idle();
        end

        repeat (3) @(negedge PCLK);
        check("final_exp_wr_empty", 32'(exp_wr.size()), 32'd0);
        check("final_exp_gnt_empty", 32'(exp_gnt.size()), 32'd0);
        check("final_exp_ack_empty", 32'(exp_ack.size()), 32'd0);
        check("final_exp_err_zero", 32'(exp_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
